// File: rtl/rf_pkg.sv
// Shared definitions for the register-file data path: widths, PPP byte-mask codes
// and the dump reader state encoding.
package rf_pkg;

    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 64;
    localparam int PPP_WIDTH  = 3;

    localparam logic [PPP_WIDTH-1:0] PPP_ALL   = 3'b000;
    localparam logic [PPP_WIDTH-1:0] PPP_UPPER = 3'b001;
    localparam logic [PPP_WIDTH-1:0] PPP_LOWER = 3'b010;
    localparam logic [PPP_WIDTH-1:0] PPP_EVEN  = 3'b011;
    localparam logic [PPP_WIDTH-1:0] PPP_ODD   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } dump_state_t;

endpackage

// File: rtl/ppp_byte_mask.sv
// PPP code to per-bit keep mask. Big-endian: byte 0 is bits 0:7 (MSB first).
// Shared with the register file's selective write path.
module ppp_byte_mask #(
    parameter int DATA_WIDTH = rf_pkg::DATA_WIDTH
) (
    input  logic [2:0]            sel,
    output logic [0:DATA_WIDTH-1] bit_mask
);
    import rf_pkg::*;

    localparam int NUM_BYTES = DATA_WIDTH / 8;

    logic [0:NUM_BYTES-1] byte_en;

    // Reserved codes fall through to "keep everything".
    always_comb begin
        byte_en = '1;
        for (int k = 0; k < NUM_BYTES; k++) begin
            case (sel)
                PPP_ALL:   byte_en[k] = 1'b1;
                PPP_UPPER: byte_en[k] = (k < NUM_BYTES / 2);
                PPP_LOWER: byte_en[k] = (k >= NUM_BYTES / 2);
                PPP_EVEN:  byte_en[k] = ((k % 2) == 0);
                PPP_ODD:   byte_en[k] = ((k % 2) == 1);
                default:   byte_en[k] = 1'b1;
            endcase
        end
    end

    always_comb begin
        bit_mask = '0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            bit_mask[b] = byte_en[b / 8];
        end
    end

endmodule

// File: rtl/rf_dump_reader.sv
// Walks an inclusive (wrapping) address range on RF read port 0 and streams each
// PPP-masked word out over valid/ready, tagged with its address.
//
//  state | meaning
//  IDLE  | waiting for start; range and sel latched on accept
//  READ  | rf_rd_addr = cur_addr, capture masked word into output register
//  HOLD  | out_valid high, wait for out_ready; then advance or finish
//  DONE  | one-cycle done pulse, back to IDLE
module rf_dump_reader #(
    parameter int ADDR_WIDTH = rf_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = rf_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    input  logic [2:0]            sel,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rf_rd_addr,
    input  logic [0:DATA_WIDTH-1] rf_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [0:DATA_WIDTH-1] out_data
);
    import rf_pkg::*;

    dump_state_t state;
    dump_state_t state_nxt;

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] last_q;
    logic [2:0]            sel_q;
    logic [0:DATA_WIDTH-1] rd_mask;

    logic start_accept;
    logic capture;
    logic handshake;
    logic at_last;

    ppp_byte_mask #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mask (
        .sel      (sel_q),
        .bit_mask (rd_mask)
    );

    assign at_last = (cur_addr == last_q);

    // cur_addr only moves when entering READ, so the RF address is stable
    // everywhere else and never drops back to 0 except on reset.
    assign rf_rd_addr = cur_addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_READ;
            ST_READ: state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (out_ready) begin
                    state_nxt = at_last ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        start_accept = 1'b0;
        capture      = 1'b0;
        handshake    = 1'b0;
        case (state)
            ST_IDLE: start_accept = start;
            ST_READ: begin
                busy    = 1'b1;
                capture = 1'b1;
            end
            ST_HOLD: begin
                busy      = 1'b1;
                handshake = out_ready;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_addr  <= '0;
            last_q    <= '0;
            sel_q     <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            if (start_accept) begin
                cur_addr <= first_addr;
                last_q   <= last_addr;
                sel_q    <= sel;
            end
            if (capture) begin
                out_data  <= rf_rd_data & rd_mask;
                out_addr  <= cur_addr;
                out_valid <= 1'b1;
            end
            if (handshake) begin
                out_valid <= 1'b0;
                if (!at_last) begin
                    cur_addr <= cur_addr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader: full sweep timing, backpressure, PPP masks,
// wrapping range with an ignored start, and reset in the middle of a dump.
module tb_rf_dump_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  first_addr;
    logic [4:0]  last_addr;
    logic [2:0]  sel;
    logic        busy;
    logic        done;
    logic [4:0]  rf_rd_addr;
    logic [0:63] rf_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [0:63] out_data;

    logic [0:63] rf_mem [0:31];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign rf_rd_data = rf_mem[rf_rd_addr];

    rf_dump_reader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .sel        (sel),
        .busy       (busy),
        .done       (done),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pattern(input int i);
        logic [63:0] p;
        p = 64'h0101_0101_0101_0101 * i;
        return p;
    endfunction

    // Leaves the bench at the negedge of the READ cycle with start low.
    task automatic start_dump(input logic [4:0] f, input logic [4:0] l, input logic [2:0] s);
        @(negedge clk);
        start      = 1'b1;
        first_addr = f;
        last_addr  = l;
        sel        = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic get_word(output logic [4:0] a, output logic [63:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check_val("word_timeout", 64'(out_valid), 64'd1);
        a = out_addr;
        d = out_data;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("done_seen", 64'(done), 64'd1);
        @(negedge clk);
        check_val("busy_after_done", 64'(busy), 64'd0);
    endtask

    typedef struct {
        logic [2:0]  code;
        logic [63:0] exp;
    } ppp_vec_t;

    initial begin
        logic [4:0]  a;
        logic [63:0] d;
        int          nword;
        int          done_cnt;
        int          done_cyc;
        int          first_valid_cyc;
        ppp_vec_t    ppp_tab [6];
        logic [4:0]  wrap_exp [4];

        for (int i = 0; i < 32; i++) rf_mem[i] = pattern(i);

        reset      = 1'b1;
        start      = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        sel        = '0;
        out_ready  = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_valid", 64'(out_valid), 64'd0);
        check_val("rst_rd_addr", 64'(rf_rd_addr), 64'd0);
        check_val("rst_out_addr", 64'(out_addr), 64'd0);
        check_val("rst_out_data", out_data, 64'd0);
        reset = 1'b0;

        // Full sweep: word i valid in cycle 2+2i, done in cycle 65.
        start_dump(5'd0, 5'd31, 3'b000);
        check_val("sweep_busy", 64'(busy), 64'd1);
        nword = 0; done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
        for (int c = 1; c <= 70; c++) begin
            if (c > 1) @(negedge clk);
            if (out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = c;
                check_val("sweep_addr", 64'(out_addr), 64'(nword));
                check_val("sweep_data", out_data, pattern(nword));
                nword++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
        end
        check_val("sweep_latency", 64'(first_valid_cyc), 64'd2);
        check_val("sweep_nwords", 64'(nword), 64'd32);
        check_val("sweep_done_cnt", 64'(done_cnt), 64'd1);
        check_val("sweep_done_cyc", 64'(done_cyc), 64'd65);
        check_val("sweep_busy_end", 64'(busy), 64'd0);

        // Backpressure
        rf_mem[5] = 64'hdead_beef_cafe_f00d;
        out_ready = 1'b0;
        start_dump(5'd5, 5'd6, 3'b000);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_val("bp_valid", 64'(out_valid), 64'd1);
            check_val("bp_addr", 64'(out_addr), 64'd5);
            check_val("bp_data", out_data, 64'hdead_beef_cafe_f00d);
        end
        out_ready = 1'b1;
        get_word(a, d);
        check_val("bp_addr6", 64'(a), 64'd6);
        check_val("bp_data6", d, pattern(6));
        wait_done();
        rf_mem[5] = pattern(5);

        // PPP masks
        rf_mem[3] = 64'h0011_2233_4455_6677;
        ppp_tab[0] = '{3'b000, 64'h0011_2233_4455_6677};
        ppp_tab[1] = '{3'b001, 64'h0011_2233_0000_0000};
        ppp_tab[2] = '{3'b010, 64'h0000_0000_4455_6677};
        ppp_tab[3] = '{3'b011, 64'h0000_2200_4400_6600};
        ppp_tab[4] = '{3'b100, 64'h0011_0033_0055_0077};
        ppp_tab[5] = '{3'b111, 64'h0011_2233_4455_6677};
        for (int i = 0; i < 6; i++) begin
            start_dump(5'd3, 5'd3, ppp_tab[i].code);
            get_word(a, d);
            check_val($sformatf("ppp%0d_addr", i), 64'(a), 64'd3);
            check_val($sformatf("ppp%0d_data", i), d, ppp_tab[i].exp);
            wait_done();
        end
        rf_mem[3] = pattern(3);

        // Wrap 30..1 with a start mid-dump that must be ignored
        wrap_exp = '{5'd30, 5'd31, 5'd0, 5'd1};
        start_dump(5'd30, 5'd1, 3'b000);
        for (int i = 0; i < 4; i++) begin
            get_word(a, d);
            check_val($sformatf("wrap%0d_addr", i), 64'(a), 64'(wrap_exp[i]));
            check_val($sformatf("wrap%0d_data", i), d, pattern(int'(wrap_exp[i])));
            if (i == 0) begin
                start      = 1'b1;
                first_addr = 5'd7;
                last_addr  = 5'd7;
                sel        = 3'b001;
                @(negedge clk);
                start = 1'b0;
            end
        end
        @(negedge clk);
        check_val("wrap_done", 64'(done), 64'd1);
        @(negedge clk);
        check_val("wrap_idle_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check_val("wrap_no_extra", 64'(out_valid), 64'd0);

        // Reset while holding address 10
        out_ready = 1'b0;
        start_dump(5'd10, 5'd20, 3'b000);
        get_word(a, d);
        check_val("mid_addr", 64'(a), 64'd10);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("mid_valid", 64'(out_valid), 64'd0);
        check_val("mid_busy", 64'(busy), 64'd0);
        check_val("mid_done", 64'(done), 64'd0);
        check_val("mid_rd_addr", 64'(rf_rd_addr), 64'd0);
        check_val("mid_out_data", out_data, 64'd0);
        out_ready = 1'b1;
        start_dump(5'd4, 5'd5, 3'b010);
        for (int i = 4; i <= 5; i++) begin
            get_word(a, d);
            check_val("post_addr", 64'(a), 64'(i));
            check_val("post_data", d, pattern(i) & 64'h0000_0000_ffff_ffff);
        end
        wait_done();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rf_dump_reader.md
Name: rf_dump_reader

Overview:
- Sequential reader for the 32x64 register file: on a start pulse, walks an address range on the RF read port 0 and streams each word out over a valid/ready interface, tagged with its address.
- Read data is optionally byte-masked by a PPP field: 000 = all, 001 = upper, 010 = lower, 011 = even bytes, 100 = odd bytes.
- Sits beside the register file as the read/drain end of the RF data path. Used for debug dumps and end-of-test content checks, where it replaces bench-side address sweeping.

Parameters:
- ADDR_WIDTH, 5, RF address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 64, RF word width; big-endian vectors [0:DATA_WIDTH-1], bit 0 = MSB, byte 0 = bits 0:7.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- first_addr  in  ADDR_WIDTH  first address of range; latched on accepted start.
- last_addr  in  ADDR_WIDTH  last address of range, inclusive; latched on accepted start.
- sel  in  3  PPP mask code; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start through the DONE state.
- done  out  1  one-cycle pulse after the last word handshakes.
- rf_rd_addr  out  ADDR_WIDTH  drives RF addr_rd_0.
- rf_rd_data  in  DATA_WIDTH  RF data_out_0; combinational from rf_rd_addr.
- out_valid  out  1  out_addr/out_data valid.
- out_ready  in  1  downstream accept.
- out_addr  out  ADDR_WIDTH  address of streamed word.
- out_data  out  DATA_WIDTH  masked RF word.

Behaviour:
- Reset: state = IDLE. busy, done, out_valid, rf_rd_addr, out_addr and out_data are all 0. Latched range and sel are cleared.
- FSM states: IDLE, READ, HOLD, DONE.
- IDLE:
  - start=1 latches first_addr, last_addr and sel; cur_addr <= first_addr; next state READ.
  - start=0 stays in IDLE.
- READ (1 cycle):
  - rf_rd_addr = cur_addr.
  - At the clock edge: out_data <= rf_rd_data & mask(sel); out_addr <= cur_addr; out_valid <= 1; next state HOLD.
  - Latency from accepted start to first out_valid = 2 cycles.
- HOLD:
  - out_valid=1; out_addr and out_data held stable while out_ready=0.
  - On out_valid & out_ready: out_valid <= 0.
    - If cur_addr == last_addr, next state DONE.
    - Otherwise cur_addr <= cur_addr + 1 mod 2**ADDR_WIDTH, next state READ.
  - Throughput: 1 word per 2 cycles with out_ready held at 1.
- DONE (1 cycle): done=1, busy=1; next state IDLE.
- Range wrap-around:
  - last_addr < first_addr wraps through 31 -> 0; e.g. 30..1 yields 30, 31, 0, 1.
  - first_addr == last_addr yields exactly one word.
  - Full sweep is first=0, last=31 (32 words).
- Mask(sel), per byte k = 0..7:
  - 000: all bytes kept.
  - 001: bytes 0-3 kept (bits 0:31).
  - 010: bytes 4-7 kept (bits 32:63).
  - 011: even bytes 0, 2, 4, 6 kept.
  - 100: odd bytes 1, 3, 5, 7 kept.
  - 101-111: reserved, treated as 000.
  - Unselected bytes are driven 0.
- Simultaneous events:
  - start while not IDLE is ignored, with no effect on the latched range.
  - out_ready while out_valid=0 is ignored.
- Reset mid-dump: next cycle is IDLE with all outputs 0. No done pulse; the partially delivered word is dropped.
- rf_rd_addr holds its last value outside READ (no glitching back to 0) until reset.

Decomposition:
- Shared package rf_pkg holds:
  - ADDR_WIDTH and DATA_WIDTH constants.
  - PPP code constants: PPP_ALL=000, PPP_UPPER=001, PPP_LOWER=010, PPP_EVEN=011, PPP_ODD=100.
  - FSM state encoding.
- One combinational sub-module, ppp_byte_mask (sel -> 8-bit byte-enable, expanded to DATA_WIDTH). It is reusable by the register file's selective write path.

Test Plan:
- Full sweep, no backpressure: preload RF[i] = 64'h0101_0101_0101_0101 * i; start with first=0, last=31, sel=000, out_ready=1 -> 32 words in address order 0..31 with exact data; done pulses once, 65 cycles after the start cycle; busy then drops.
- Backpressure: first=5, last=6, RF[5]=64'hdead_beef_cafe_f00d; hold out_ready=0 for 4 cycles -> out_addr=5 and out_data stay stable with out_valid=1 throughout; word 6 follows only after out_ready goes to 1.
- PPP masks on RF[3]=64'h0011_2233_4455_6677, first=last=3:
  - 001 -> 64'h0011_2233_0000_0000
  - 010 -> 64'h0000_0000_4455_6677
  - 011 -> 64'h0000_2200_4400_6600
  - 100 -> 64'h0011_0033_0055_0077
  - 111 -> the unmasked word.
- Wrap range: first=30, last=1 -> out_addr sequence 30, 31, 0, 1, then done; a start issued during the dump is ignored.
- Reset mid-dump: reset asserted while in HOLD at address 10 -> next cycle out_valid=0, busy=0, done=0, rf_rd_addr=0; a fresh start afterwards dumps correctly from its own first_addr.
